// File: rtl/game_sequencer.sv
// Flappy-style game sequencer: frame tick generation, button edge capture,
// game state machine, collision/pass detection and two-digit BCD score.
module game_sequencer #(
    parameter int unsigned TICK_DIV     = 1666666,
    parameter int unsigned CRASH_FRAMES = 30,
    parameter int unsigned BIRD_X_L     = 230,
    parameter int unsigned BIRD_X_R     = 250
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       BtnStart,
    input  logic       BtnFlap,
    input  logic [9:0] Bird_Y_T,
    input  logic [9:0] Bird_Y_B,
    input  logic [9:0] Pipe_X_L,
    input  logic [9:0] Pipe_X_R,
    input  logic [9:0] Gap_Y_T,
    input  logic [9:0] Gap_Y_B,
    output logic       FrameTick,
    output logic       Start,
    output logic       Ack,
    output logic       Stop,
    output logic       BtnPress,
    output logic [7:0] Score,
    output logic       q_Idle,
    output logic       q_Play,
    output logic       q_Crash,
    output logic       q_Over
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CRS_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;
    localparam logic [9:0]  XL    = 10'(BIRD_X_L);
    localparam logic [9:0]  XR    = 10'(BIRD_X_R);
    localparam logic [9:0]  FLOOR = 10'd480;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        PLAY  = 4'b0010,
        CRASH = 4'b0100,
        OVER  = 4'b1000
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CRS_W-1:0]   crash_cnt;
    logic [1:0]         start_sync;
    logic [1:0]         flap_sync;
    logic               start_hist;
    logic               flap_hist;
    logic               pending;
    logic [9:0]         prev_xr;

    logic               tick_next;
    logic               start_edge;
    logic               flap_edge;
    logic               in_column;
    logic               hit;
    logic               pass;

    assign tick_next  = (frame_cnt == CNT_W'(TICK_DIV - 1));
    assign start_edge = start_sync[1] & ~start_hist;
    assign flap_edge  = flap_sync[1] & ~flap_hist;

    // Collision and pass tests, only acted on during FrameTick cycles in PLAY
    assign in_column = (Pipe_X_L <= XR) && (Pipe_X_R >= XL);
    assign hit       = (Bird_Y_B >= FLOOR) || (Bird_Y_T == 10'd0) ||
                       (in_column && ((Bird_Y_T < Gap_Y_T) || (Bird_Y_B > Gap_Y_B)));
    assign pass      = (Pipe_X_R < XL) && (prev_xr >= XL);

    assign q_Idle  = (state == IDLE);
    assign q_Play  = (state == PLAY);
    assign q_Crash = (state == CRASH);
    assign q_Over  = (state == OVER);

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        else if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        else
            return {s[7:4], s[3:0] + 4'd1};
    endfunction

    // Free-running frame divider
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            FrameTick <= 1'b0;
        end else begin
            FrameTick <= tick_next;
            frame_cnt <= tick_next ? '0 : frame_cnt + CNT_W'(1);
        end
    end

    // Button synchronizers with one history flop for rising-edge detect
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            flap_sync  <= '0;
            start_hist <= 1'b0;
            flap_hist  <= 1'b0;
        end else begin
            start_sync <= {start_sync[0], BtnStart};
            flap_sync  <= {flap_sync[0], BtnFlap};
            start_hist <= start_sync[1];
            flap_hist  <= flap_sync[1];
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            crash_cnt <= '0;
            pending   <= 1'b0;
            Score     <= 8'h00;
            Start     <= 1'b0;
            Ack       <= 1'b0;
            Stop      <= 1'b0;
            BtnPress  <= 1'b0;
            prev_xr   <= '0;
        end else begin
            Start    <= 1'b0;
            Ack      <= 1'b0;
            BtnPress <= 1'b0;
            if (FrameTick)
                prev_xr <= Pipe_X_R;
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (start_edge) begin
                        state <= PLAY;
                        Start <= 1'b1;
                        Score <= 8'h00;
                    end
                end
                PLAY: begin
                    if (FrameTick && hit) begin
                        state     <= CRASH;
                        Stop      <= 1'b1;
                        pending   <= 1'b0;
                        crash_cnt <= '0;
                    end else begin
                        if (FrameTick && pass)
                            Score <= bcd_inc(Score);
                        // An edge landing on the serving edge waits for the next frame
                        if (tick_next) begin
                            BtnPress <= pending;
                            pending  <= flap_edge;
                        end else if (flap_edge) begin
                            pending <= 1'b1;
                        end
                    end
                end
                CRASH: begin
                    if (FrameTick) begin
                        if (crash_cnt == CRS_W'(CRASH_FRAMES - 1))
                            state <= OVER;
                        else
                            crash_cnt <= crash_cnt + CRS_W'(1);
                    end
                end
                OVER: begin
                    if (start_edge) begin
                        state <= IDLE;
                        Ack   <= 1'b1;
                        Stop  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, CRASH_FRAMES=3.
module tb_game_sequencer;

    logic       Clk = 1'b0;
    logic       reset;
    logic       BtnStart, BtnFlap;
    logic [9:0] Bird_Y_T, Bird_Y_B, Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B;
    logic       FrameTick, Start, Ack, Stop, BtnPress;
    logic [7:0] Score;
    logic       q_Idle, q_Play, q_Crash, q_Over;

    int tests  = 0;
    int failed = 0;

    localparam logic [3:0] S_IDLE = 4'b0001, S_PLAY = 4'b0010,
                           S_CRASH = 4'b0100, S_OVER = 4'b1000;

    game_sequencer #(.TICK_DIV(4), .CRASH_FRAMES(3), .BIRD_X_L(230), .BIRD_X_R(250)) dut (
        .Clk(Clk), .reset(reset), .BtnStart(BtnStart), .BtnFlap(BtnFlap),
        .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B), .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R),
        .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B), .FrameTick(FrameTick), .Start(Start),
        .Ack(Ack), .Stop(Stop), .BtnPress(BtnPress), .Score(Score),
        .q_Idle(q_Idle), .q_Play(q_Play), .q_Crash(q_Crash), .q_Over(q_Over)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] pl, pr, bt, bb, gt, gb;
        logic [7:0] score;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [3:0] st_now();
        return {q_Over, q_Crash, q_Play, q_Idle};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs, run through the next FrameTick cycle, return one negedge later
    task automatic frame(input logic [9:0] pl, pr, bt, bb, gt, gb);
        bit seen = 0;
        Pipe_X_L = pl; Pipe_X_R = pr; Bird_Y_T = bt; Bird_Y_B = bb;
        Gap_Y_T = gt; Gap_Y_B = gb;
        for (int i = 0; i < 10; i++) begin
            if (FrameTick) begin
                seen = 1;
                break;
            end
            @(negedge Clk);
        end
        if (!seen) check("frame_tick_timeout", 32'(0), 32'(1));
        @(negedge Clk);
    endtask

    // Pulse BtnStart for two cycles and report first-seen latency of Start/Ack
    task automatic start_press(output int lat_s, output int lat_a, output int n_s, output int n_a);
        lat_s = 0; lat_a = 0; n_s = 0; n_a = 0;
        BtnStart = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            if (i == 2) BtnStart = 1'b0;
            if (Start) begin n_s++; if (lat_s == 0) lat_s = i; end
            if (Ack)   begin n_a++; if (lat_a == 0) lat_a = i; end
        end
    endtask

    initial begin
        int last, lat_s, lat_a, n_s, n_a, presses, pos, n;
        logic [7:0] exp_sc;

        vecs[0] = '{10'd220, 10'd231, 10'd100, 10'd120, 10'd80, 10'd200, 8'h00, S_PLAY};
        vecs[1] = '{10'd210, 10'd229, 10'd100, 10'd120, 10'd80, 10'd200, 8'h01, S_PLAY};
        vecs[2] = '{10'd209, 10'd228, 10'd100, 10'd120, 10'd80, 10'd200, 8'h01, S_PLAY};
        vecs[3] = '{10'd240, 10'd260, 10'd100, 10'd120, 10'd80, 10'd200, 8'h01, S_PLAY};
        vecs[4] = '{10'd225, 10'd231, 10'd100, 10'd120, 10'd80, 10'd200, 8'h01, S_PLAY};
        vecs[5] = '{10'd200, 10'd229, 10'd100, 10'd120, 10'd80, 10'd200, 8'h02, S_PLAY};
        vecs[6] = '{10'd500, 10'd520, 10'd100, 10'd120, 10'd80, 10'd200, 8'h02, S_PLAY};

        reset = 1'b1; BtnStart = 1'b0; BtnFlap = 1'b0;
        Bird_Y_T = 10'd100; Bird_Y_B = 10'd120; Gap_Y_T = 10'd80; Gap_Y_B = 10'd200;
        Pipe_X_L = 10'd500; Pipe_X_R = 10'd520;
        @(negedge Clk); @(negedge Clk);
        check("reset_state", 32'(st_now()), 32'(S_IDLE));
        check("reset_score", 32'(Score), 32'h00);
        check("reset_outs", 32'({FrameTick, Start, Ack, Stop, BtnPress}), 32'(0));
        reset = 1'b0;

        // FrameTick period
        last = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (FrameTick) begin
                if (last >= 0) check("tick_period", 32'(i - last), 32'(4));
                last = i;
            end
        end
        check("tick_seen", 32'(last >= 0), 32'(1));

        // Flap outside PLAY is ignored
        presses = 0;
        BtnFlap = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (i == 1) BtnFlap = 1'b0;
            if (BtnPress) presses++;
        end
        check("idle_flap_nopress", 32'(presses), 32'(0));

        start_press(lat_s, lat_a, n_s, n_a);
        check("start_latency", 32'(lat_s), 32'(3));
        check("start_width", 32'(n_s), 32'(1));
        check("play_state", 32'(st_now()), 32'(S_PLAY));
        check("play_score", 32'(Score), 32'h00);

        // Start in PLAY has no effect
        start_press(lat_s, lat_a, n_s, n_a);
        check("play_start_ignored", 32'(n_s + n_a), 32'(0));
        check("play_state_kept", 32'(st_now()), 32'(S_PLAY));

        // Two flap edges in one frame, the first on a FrameTick cycle
        pos = -1; presses = 0;
        for (int i = 0; i < 10 && !FrameTick; i++) @(negedge Clk);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge Clk);
            if (BtnPress) begin
                presses++;
                pos = c;
                check("press_on_tick", 32'(FrameTick), 32'(1));
            end
            BtnFlap = (c == 2 || c == 4);
        end
        check("flap_single_press", 32'(presses), 32'(1));
        check("flap_press_pos", 32'(pos), 32'(8));

        // Table of per-frame pipe/bird positions
        foreach (vecs[k]) begin
            frame(vecs[k].pl, vecs[k].pr, vecs[k].bt, vecs[k].bb, vecs[k].gt, vecs[k].gb);
            check($sformatf("vec%0d_score", k), 32'(Score), 32'(vecs[k].score));
            check($sformatf("vec%0d_state", k), 32'(st_now()), 32'(vecs[k].st));
        end

        // Repeated passes: BCD carry and saturation at 99
        n = 2;
        while (n < 100) begin
            frame(10'd220, 10'd231, 10'd100, 10'd120, 10'd80, 10'd200);
            frame(10'd210, 10'd229, 10'd100, 10'd120, 10'd80, 10'd200);
            n++;
            exp_sc = (n >= 99) ? 8'h99 : {4'(n / 10), 4'(n % 10)};
            check($sformatf("score_pass%0d", n), 32'(Score), 32'(exp_sc));
        end

        // Hit and pass on the same tick: crash, score unchanged
        frame(10'd220, 10'd231, 10'd100, 10'd120, 10'd80, 10'd200);
        frame(10'd210, 10'd229, 10'd100, 10'd480, 10'd80, 10'd200);
        check("floor_crash_state", 32'(st_now()), 32'(S_CRASH));
        check("floor_crash_stop", 32'(Stop), 32'(1));
        check("floor_crash_score", 32'(Score), 32'h99);

        // CRASH ignores buttons and lasts three ticks
        BtnStart = 1'b1;
        frame(10'd500, 10'd520, 10'd100, 10'd120, 10'd80, 10'd200);
        BtnStart = 1'b0;
        check("crash_tick1", 32'(st_now()), 32'(S_CRASH));
        frame(10'd500, 10'd520, 10'd100, 10'd120, 10'd80, 10'd200);
        check("crash_tick2", 32'(st_now()), 32'(S_CRASH));
        frame(10'd500, 10'd520, 10'd100, 10'd120, 10'd80, 10'd200);
        check("crash_tick3_over", 32'(st_now()), 32'(S_OVER));
        check("over_stop", 32'(Stop), 32'(1));

        start_press(lat_s, lat_a, n_s, n_a);
        check("ack_latency", 32'(lat_a), 32'(3));
        check("ack_width", 32'(n_a), 32'(1));
        check("ack_no_start", 32'(n_s), 32'(0));
        check("ack_idle", 32'(st_now()), 32'(S_IDLE));
        check("idle_score_held", 32'(Score), 32'h99);
        check("idle_stop", 32'(Stop), 32'(0));

        start_press(lat_s, lat_a, n_s, n_a);
        check("restart_latency", 32'(lat_s), 32'(3));
        check("restart_score", 32'(Score), 32'h00);

        // Pipe collision outside the gap
        frame(10'd220, 10'd231, 10'd100, 10'd120, 10'd80, 10'd200);
        frame(10'd210, 10'd229, 10'd100, 10'd120, 10'd80, 10'd200);
        check("pre_hit_score", 32'(Score), 32'h01);
        frame(10'd240, 10'd260, 10'd100, 10'd120, 10'd150, 10'd200);
        check("pipe_crash_state", 32'(st_now()), 32'(S_CRASH));
        check("pipe_crash_stop", 32'(Stop), 32'(1));
        frame(10'd500, 10'd520, 10'd100, 10'd120, 10'd80, 10'd200);
        check("pipe_crash_hold", 32'(st_now()), 32'(S_CRASH));

        // Reset mid-CRASH
        reset = 1'b1;
        #1;
        check("midreset_state", 32'(st_now()), 32'(S_IDLE));
        check("midreset_stop", 32'(Stop), 32'(0));
        check("midreset_score", 32'(Score), 32'h00);
        @(negedge Clk);
        reset = 1'b0;
        n_a = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Ack || Start) n_a++;
        end
        check("midreset_no_ack", 32'(n_a), 32'(0));
        start_press(lat_s, lat_a, n_s, n_a);
        check("resume_latency", 32'(lat_s), 32'(3));
        check("resume_state", 32'(st_now()), 32'(S_PLAY));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1666666, Clk cycles per frame tick (60 Hz at 100 MHz).
REQ-002 SHALL have parameter CRASH_FRAMES, default 30, frame ticks spent in CRASH before OVER.
REQ-003 SHALL have parameters BIRD_X_L/BIRD_X_R, defaults 230/250, fixed bird column in pixels.
REQ-004 SHALL have port Clk  in  1  system clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports BtnStart, BtnFlap  in  1 each  raw debounced buttons, asynchronous to Clk.
REQ-007 SHALL have ports Bird_Y_T, Bird_Y_B  in  10 each  bird box top/bottom row from flight physics.
REQ-008 SHALL have ports Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B  in  10 each  current pipe box and gap rows.
REQ-009 SHALL have port FrameTick  out  1  one-cycle frame enable for physics and pipe blocks.
REQ-010 SHALL have ports Start, Ack  out  1 each  one-cycle pulses to physics/pipe FSMs.
REQ-011 SHALL have port Stop  out  1  level, high in CRASH and OVER.
REQ-012 SHALL have port BtnPress  out  1  flap request to physics.
REQ-013 SHALL have port Score  out  8  two BCD digits, [7:4] tens, [3:0] units.
REQ-014 SHALL have ports q_Idle, q_Play, q_Crash, q_Over  out  1 each  one-hot state.

Function
REQ-015 Frame counter SHALL count 0..TICK_DIV-1 and wrap, free-running in all states; FrameTick registered, high exactly the cycle after count = TICK_DIV-1.
REQ-016 Each button SHALL pass a 2-flop synchronizer plus one history flop; edge = sync & ~history; release edges ignored.
REQ-017 FSM states SHALL be IDLE, PLAY, CRASH, OVER, one-hot, exported on q_*.
REQ-018 IDLE: BtnStart edge -> PLAY next cycle; Start high that same cycle only; Score cleared to 0x00.
REQ-019 PLAY: BtnFlap edge sets a pending flag; BtnPress SHALL be high only on the next FrameTick cycle, then pending clears; multiple edges in one frame yield one BtnPress.
REQ-020 Flap edge coinciding with a FrameTick cycle SHALL be served at the following FrameTick, not the current one.
REQ-021 Collision SHALL be evaluated only on FrameTick cycles in PLAY: hit = (Bird_Y_B >= 480) or (Bird_Y_T == 0) or (Pipe_X_L <= BIRD_X_R and Pipe_X_R >= BIRD_X_L and (Bird_Y_T < Gap_Y_T or Bird_Y_B > Gap_Y_B)); all compares unsigned 10-bit.
REQ-022 Hit SHALL move PLAY -> CRASH on the next cycle; Stop rises the same edge; pending flap discarded.
REQ-023 Pass SHALL be detected on FrameTick in PLAY when Pipe_X_R < BIRD_X_L and the registered previous-frame Pipe_X_R >= BIRD_X_L; each pass increments Score once in BCD (09->10, 99 saturates).
REQ-024 Hit and pass on the same tick: hit wins, Score unchanged.
REQ-025 CRASH: count CRASH_FRAMES FrameTicks, then OVER; buttons ignored.
REQ-026 OVER: BtnStart edge -> IDLE next cycle with Ack high that cycle only; Score held until next Start.
REQ-027 BtnStart in PLAY and BtnFlap outside PLAY SHALL have no effect.

Reset
REQ-028 reset SHALL asynchronously force IDLE, frame/crash counters 0, sync/history flops 0, pending 0, Score 0x00, FrameTick/Start/Ack/Stop/BtnPress 0.
REQ-029 reset mid-PLAY or mid-CRASH SHALL abort to IDLE with no Ack pulse; operation resumes on first edge after release.

Verification (TICK_DIV=4, CRASH_FRAMES=3)
REQ-030 Reset release, BtnStart pulse -> Start high one cycle ~3 cycles later, q_Play=1, Score=0x00; FrameTick every 4 cycles.
REQ-031 Two BtnFlap pulses within one frame -> exactly one BtnPress, aligned with FrameTick.
REQ-032 Pipe_X_R steps 231->229 across ticks, gap clear -> Score 0x00->0x01; repeat from 0x09 -> 0x10; from 0x99 -> stays 0x99.
REQ-033 Bird_Y_T=100, Gap_Y_T=150, Pipe_X_L=240 on tick -> q_Crash, Stop=1; 3 ticks later q_Over; BtnStart -> Ack one cycle, q_Idle.
REQ-034 Bird_Y_B=480 with pass condition same tick -> crash, Score unchanged.
REQ-035 reset asserted mid-CRASH -> q_Idle, Stop=0, Score=0x00 immediately, no Ack.
